// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button debounce, 1 Hz timebase with fast-forward/pause, RUN/SET_HR/SET_MIN edit FSM; define CLK_CTRL_AUTOREPEAT_EN for held-increment auto-repeat
module clock_set_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int FF_DIV        = 50,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pb,
  output logic       tick_sec,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       paused,
  output logic       ff_active
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2(CLK_HZ + FF_DIV);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [CW:0] HZ = (CW + 1)'(CLK_HZ);
  if (DEB_CYCLES < 1 || BLINK_HALF < 1 || REPEAT_CYCLES < 4) begin : g_bad_cfg
    $error("clock_set_ctrl: invalid parameters");
  end
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;
  state_t state, state_nx;
  logic [3:0] s1, s2, deb;
  logic [2:0] key_q;
  logic [DW-1:0] dcnt [4];
  logic p_mode, p_inc, p_pause, is_hr, is_min, is_run, wrap, inc_req, phase;
  logic [CW-1:0] cnt;
  logic [CW:0] sum;
  logic [BW-1:0] bcnt;
  always_comb begin
    is_hr = state == SET_HR;
    is_min = state == SET_MIN;
    is_run = !is_hr && !is_min;
    {p_pause, p_inc, p_mode} = {deb[3], deb[1], deb[0]} & ~key_q;
    ff_active = is_run && deb[2] && !paused;
    sum = {1'b0, cnt} + (ff_active ? (CW + 1)'(FF_DIV) : (CW + 1)'(1));
    wrap = sum >= HZ;
    state_nx = state;
    if (p_mode)
      case (state)
        SET_HR:  state_nx = SET_MIN;
        SET_MIN: state_nx = RUN;
        default: state_nx = SET_HR;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      key_q <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      s1 <= pb;
      s2 <= s1;
      key_q <= {deb[3], deb[1], deb[0]};
      for (int i = 0; i < 4; i++)
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          dcnt[i] <= '0;
          deb[i] <= s2[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  end
  // remainder is carried across the wrap so fast-forward never drifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      paused <= 1'b0;
      tick_sec <= 1'b0;
      inc_hr <= 1'b0;
      inc_min <= 1'b0;
      sec_clr <= 1'b0;
    end else begin
      state <= state_nx;
      tick_sec <= is_run && !paused && wrap;
      cnt <= !is_run ? '0 : paused ? cnt : wrap ? CW'(sum - HZ) : CW'(sum);
      paused <= paused ^ (p_pause && is_run);
      sec_clr <= p_mode && is_min;
      inc_hr <= inc_req && is_hr && !p_mode;
      inc_min <= inc_req && is_min && !p_mode;
      bcnt <= (p_mode || is_run || bcnt == BW'(BLINK_HALF - 1)) ? '0 : bcnt + 1'b1;
      phase <= (p_mode || is_run) ? 1'b0 : phase ^ (bcnt == BW'(BLINK_HALF - 1));
    end
  end
`ifdef CLK_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rcnt;
  logic rlate, held, rep;
  // counting starts the cycle after the press pulse so the first repeat lands REPEAT_CYCLES after it
  assign held = deb[1] && key_q[1] && !is_run && !p_mode;
  assign rep = held && rcnt == (rlate ? RW'(REPEAT_CYCLES / 4 - 1) : RW'(REPEAT_CYCLES - 1));
  assign inc_req = p_inc || rep;
  always_ff @(posedge clk) begin
    if (!rst_n || !held) begin
      rcnt <= '0;
      rlate <= 1'b0;
    end else if (rep) begin
      rcnt <= '0;
      rlate <= 1'b1;
    end else rcnt <= rcnt + 1'b1;
  end
`else
  assign inc_req = p_inc;
`endif
  assign mode = state;
  assign blank_hr = is_hr && phase;
  assign blank_min = is_min && phase;
endmodule
